alu_share_ctrl: RTL and testbench

Round-robin controller that shares one combinational 12-bit ALU (ops 0–7: A>>1, B<<1, AND, OR, XOR, ~A, ADD, SUB; outputs Z, Cout, Sign, OV) between two requesters. Each requester hands over an opcode and operands through a req/ready handshake. The block registers them onto the ALU inputs, waits a programmable settle time, and captures the result and flags. It then returns them to the owning requester with a one-cycle valid pulse. It sits between the ALU instance and its clients, and is the only driver of the ALU inputs.

---
 rtl/alu_share_ctrl.sv | 151 +++++++++++++++
 tb/tb_alu_share_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one combinational 12-bit ALU between two requesters.
// Registers operands onto the ALU, waits SETTLE cycles, then returns result/flags to the owner.
module alu_share_ctrl #(
   parameter int unsigned SETTLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic [2:0]  op0,
   input  logic [2:0]  op1,
   input  logic [11:0] a0,
   input  logic [11:0] b0,
   input  logic [11:0] a1,
   input  logic [11:0] b1,
   output logic        ready0,
   output logic        ready1,
   output logic        rsp_valid0,
   output logic        rsp_valid1,
   output logic [11:0] rsp_z0,
   output logic [11:0] rsp_z1,
   output logic [2:0]  rsp_flags0,
   output logic [2:0]  rsp_flags1,
   output logic [11:0] alu_a,
   output logic [11:0] alu_b,
   output logic [2:0]  alu_op,
   input  logic [11:0] alu_z,
   input  logic        alu_cout,
   input  logic        alu_sign,
   input  logic        alu_ov,
   output logic        busy
);

   typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic        owner_q, owner_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [11:0] alu_a_q, alu_a_d;
   logic [11:0] alu_b_q, alu_b_d;
   logic [2:0]  alu_op_q, alu_op_d;
   logic [11:0] rsp_z0_q, rsp_z0_d;
   logic [11:0] rsp_z1_q, rsp_z1_d;
   logic [2:0]  rsp_flags0_q, rsp_flags0_d;
   logic [2:0]  rsp_flags1_q, rsp_flags1_d;
   logic        rsp_valid0_q, rsp_valid0_d;
   logic        rsp_valid1_q, rsp_valid1_d;

   logic        winner;
   logic        accept;
   logic [2:0]  cap_flags;

   // On a tie the port not granted last wins; ready is held low while in reset.
   always_comb begin
      winner    = (req0 && req1) ? ~last_q : req1;
      ready0    = rst_n && (state_q == IDLE) && req0 && !winner;
      ready1    = rst_n && (state_q == IDLE) && req1 && winner;
      accept    = ready0 || ready1;
      cap_flags = {(alu_op_q[2:1] == 2'b11) && alu_cout, alu_sign, alu_ov};
   end

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      owner_d      = owner_q;
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      rsp_z0_d     = rsp_z0_q;
      rsp_z1_d     = rsp_z1_q;
      rsp_flags0_d = rsp_flags0_q;
      rsp_flags1_d = rsp_flags1_q;
      rsp_valid0_d = 1'b0;
      rsp_valid1_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               alu_op_d = winner ? op1 : op0;
               alu_a_d  = winner ? a1 : a0;
               alu_b_d  = winner ? b1 : b0;
               owner_d  = winner;
               last_d   = winner;
               cnt_d    = 4'(SETTLE);
               state_d  = EXEC;
            end
         end
         EXEC: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               if (owner_q) begin
                  rsp_z1_d     = alu_z;
                  rsp_flags1_d = cap_flags;
                  rsp_valid1_d = 1'b1;
               end else begin
                  rsp_z0_d     = alu_z;
                  rsp_flags0_d = cap_flags;
                  rsp_valid0_d = 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_q       <= 1'b1;
         owner_q      <= 1'b0;
         cnt_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         rsp_z0_q     <= '0;
         rsp_z1_q     <= '0;
         rsp_flags0_q <= '0;
         rsp_flags1_q <= '0;
         rsp_valid0_q <= 1'b0;
         rsp_valid1_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         owner_q      <= owner_d;
         cnt_q        <= cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         rsp_z0_q     <= rsp_z0_d;
         rsp_z1_q     <= rsp_z1_d;
         rsp_flags0_q <= rsp_flags0_d;
         rsp_flags1_q <= rsp_flags1_d;
         rsp_valid0_q <= rsp_valid0_d;
         rsp_valid1_q <= rsp_valid1_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_op     = alu_op_q;
   assign rsp_z0     = rsp_z0_q;
   assign rsp_z1     = rsp_z1_q;
   assign rsp_flags0 = rsp_flags0_q;
   assign rsp_flags1 = rsp_flags1_q;
   assign rsp_valid0 = rsp_valid0_q;
   assign rsp_valid1 = rsp_valid1_q;
   assign busy       = (state_q == EXEC);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: behavioural ALU on alu_*, integer reference model for responses.
module tb_alu_share_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req0, req1, ready0, ready1, rsp_valid0, rsp_valid1, busy;
   logic [2:0]  op0, op1, rsp_flags0, rsp_flags1, alu_op;
   logic [11:0] a0, b0, a1, b1, rsp_z0, rsp_z1, alu_a, alu_b, alu_z;
   logic        alu_cout, alu_sign, alu_ov;

   logic        t_req0, t_ready0, t_ready1, t_valid0, t_valid1, t_busy;
   logic [2:0]  t_op0, t_flags0, t_flags1, t_alu_op;
   logic [11:0] t_a0, t_b0, t_z0, t_z1, t_alu_a, t_alu_b, t_alu_z;
   logic        t_cout, t_sign, t_ov;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic [11:0] z;
      logic [2:0]  f;
      int          cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   grants[$];
   int   resp_cyc[$];
   logic [11:0] last_z0 = '0, last_z1 = '0;
   logic [2:0]  last_f0 = '0, last_f1 = '0;

   alu_share_ctrl #(.SETTLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
      .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .ready0(ready0), .ready1(ready1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
      .rsp_z0(rsp_z0), .rsp_z1(rsp_z1), .rsp_flags0(rsp_flags0), .rsp_flags1(rsp_flags1),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z),
      .alu_cout(alu_cout), .alu_sign(alu_sign), .alu_ov(alu_ov), .busy(busy)
   );

   alu_share_ctrl #(.SETTLE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req0(t_req0), .req1(1'b0),
      .op0(t_op0), .op1(3'd0), .a0(t_a0), .b0(t_b0), .a1(12'd0), .b1(12'd0),
      .ready0(t_ready0), .ready1(t_ready1), .rsp_valid0(t_valid0), .rsp_valid1(t_valid1),
      .rsp_z0(t_z0), .rsp_z1(t_z1), .rsp_flags0(t_flags0), .rsp_flags1(t_flags1),
      .alu_a(t_alu_a), .alu_b(t_alu_b), .alu_op(t_alu_op), .alu_z(t_alu_z),
      .alu_cout(t_cout), .alu_sign(t_sign), .alu_ov(t_ov), .busy(t_busy)
   );

   // Bit-level ALU; logic ops drive cout=1 so the controller's masking is observable.
   function automatic logic [14:0] alu_fn(logic [2:0] op, logic [11:0] a, logic [11:0] b);
      logic [11:0] z;
      logic        c;
      logic        v;
      logic [12:0] w;
      v = 1'b0;
      c = 1'b1;
      z = '0;
      case (op)
         3'd0: begin z = a >> 1; c = a[0]; end
         3'd1: begin z = b << 1; c = b[11]; end
         3'd2: z = a & b;
         3'd3: z = a | b;
         3'd4: z = a ^ b;
         3'd5: z = ~a;
         3'd6: begin w = {1'b0, a} + {1'b0, b}; z = w[11:0]; c = w[12];
                     v = (a[11] == b[11]) && (z[11] != a[11]); end
         default: begin w = {1'b0, a} - {1'b0, b}; z = w[11:0]; c = w[12];
                     v = (a[11] != b[11]) && (z[11] != a[11]); end
      endcase
      return {z, c, z[11], v};
   endfunction

   assign {alu_z, alu_cout, alu_sign, alu_ov}   = alu_fn(alu_op, alu_a, alu_b);
   assign {t_alu_z, t_cout, t_sign, t_ov}       = alu_fn(t_alu_op, t_alu_a, t_alu_b);

   // Expected response {z, Cout, Sign, OV} from integer arithmetic.
   function automatic logic [14:0] ref_rsp(int op, int a, int b);
      int z, sa, sb, r;
      logic c, v;
      c = 1'b0;
      v = 1'b0;
      z = 0;
      sa = (a >= 2048) ? a - 4096 : a;
      sb = (b >= 2048) ? b - 4096 : b;
      case (op)
         0: z = a / 2;
         1: z = (b * 2) % 4096;
         2: z = a & b;
         3: z = a | b;
         4: z = a ^ b;
         5: z = 4095 - a;
         6: begin z = (a + b) % 4096; c = (a + b) >= 4096; r = sa + sb; v = (r > 2047) || (r < -2048); end
         default: begin z = (a - b + 4096) % 4096; c = a < b; r = sa - sb; v = (r > 2047) || (r < -2048); end
      endcase
      return {z[11:0], c, z >= 2048, v};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout expected=event", name);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares responses against the queued expectations, then records new accepts.
   always @(negedge clk) begin
      exp_t e;
      logic [14:0] r;
      if (rst_n) begin
         if (ready0 && ready1) chk("ready_exclusive", 32'(ready1), 32'd0);
         if (rsp_valid0) begin
            if (q0.size() == 0) fail_now("unexpected_valid0");
            else begin
               e = q0.pop_front();
               chk("rsp_z0", 32'(rsp_z0), 32'(e.z));
               chk("rsp_flags0", 32'(rsp_flags0), 32'(e.f));
               chk("latency0", 32'(cyc), 32'(e.cyc));
               chk("hold_z1", 32'(rsp_z1), 32'(last_z1));
               chk("hold_f1", 32'(rsp_flags1), 32'(last_f1));
               last_z0 = e.z;
               last_f0 = e.f;
               resp_cyc.push_back(cyc);
            end
         end
         if (rsp_valid1) begin
            if (q1.size() == 0) fail_now("unexpected_valid1");
            else begin
               e = q1.pop_front();
               chk("rsp_z1", 32'(rsp_z1), 32'(e.z));
               chk("rsp_flags1", 32'(rsp_flags1), 32'(e.f));
               chk("latency1", 32'(cyc), 32'(e.cyc));
               chk("hold_z0", 32'(rsp_z0), 32'(last_z0));
               chk("hold_f0", 32'(rsp_flags0), 32'(last_f0));
               last_z1 = e.z;
               last_f1 = e.f;
               resp_cyc.push_back(cyc);
            end
         end
         if (req0 && ready0) begin
            r = ref_rsp(int'(op0), int'(a0), int'(b0));
            e.z = r[14:3]; e.f = r[2:0]; e.cyc = cyc + 2;
            q0.push_back(e);
            grants.push_back(0);
         end
         if (req1 && ready1) begin
            r = ref_rsp(int'(op1), int'(a1), int'(b1));
            e.z = r[14:3]; e.f = r[2:0]; e.cyc = cyc + 2;
            q1.push_back(e);
            grants.push_back(1);
         end
      end
   end

   // Called at posedge+1; leaves req high and returns at posedge+1 after the accept edge.
   task automatic send(int port, logic [2:0] op, logic [11:0] a, logic [11:0] b);
      int n = 0;
      logic rdy;
      if (port == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
      else begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
      do begin
         @(negedge clk);
         n++;
         rdy = (port == 0) ? ready0 : ready1;
      end while (!rdy && n < 60);
      if (!rdy) fail_now("send_timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (n >= 100) fail_now("drain_timeout");
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      t_req0 = 1'b0; t_op0 = '0; t_a0 = '0; t_b0 = '0;

      // Reset state, with both requests asserted
      repeat (2) @(negedge clk);
      chk("rst_ready0", 32'(ready0), 32'd0);
      chk("rst_ready1", 32'(ready1), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_alu", {8'd0, alu_op, alu_a, alu_b[11:3]}, 32'd0);
      chk("rst_rsp", {rsp_z0, rsp_z1, rsp_flags0, rsp_flags1, rsp_valid0, rsp_valid1}, 32'd0);
      req0 = 1'b0; req1 = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Contention from reset: grants 0,1,0,1 with 2-cycle response spacing
      grants.delete(); resp_cyc.delete();
      fork
         begin send(0, 3'd6, 12'd100, 12'd200); send(0, 3'd2, 12'hFF0, 12'h0F3); req0 = 1'b0; end
         begin send(1, 3'd4, 12'hAAA, 12'h555); send(1, 3'd7, 12'h010, 12'h020); req1 = 1'b0; end
      join
      drain();
      chk("grant_count", 32'(grants.size()), 32'd4);
      for (int i = 0; i < 4 && i < grants.size(); i++) chk("grant_order", 32'(grants[i]), 32'(i % 2));
      for (int i = 1; i < resp_cyc.size(); i++) chk("resp_gap", 32'(resp_cyc[i] - resp_cyc[i-1]), 32'd2);

      // Directed: add overflow, subtract borrow, Cout masking
      send(0, 3'd6, 12'h7FF, 12'h001); req0 = 1'b0; drain();
      chk("add_z0", 32'(rsp_z0), 32'h800);
      chk("add_f0", 32'(rsp_flags0), 32'b011);
      send(1, 3'd7, 12'h000, 12'h001); req1 = 1'b0; drain();
      chk("sub_z1", 32'(rsp_z1), 32'hFFF);
      chk("sub_f1", 32'(rsp_flags1), 32'b110);
      send(0, 3'd0, 12'h003, 12'h000); req0 = 1'b0; drain();
      chk("shr_z0", 32'(rsp_z0), 32'h001);
      chk("shr_cout0", 32'(rsp_flags0[2]), 32'd0);

      // Randomized traffic from both ports
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               send(0, 3'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
               if ($urandom_range(0, 1) == 1) begin
                  req0 = 1'b0;
                  repeat ($urandom_range(1, 4)) @(posedge clk);
                  #1;
               end
            end
            req0 = 1'b0;
         end
         begin
            for (int j = 0; j < 20; j++) begin
               send(1, 3'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
               if ($urandom_range(0, 1) == 1) begin
                  req1 = 1'b0;
                  repeat ($urandom_range(1, 4)) @(posedge clk);
                  #1;
               end
            end
            req1 = 1'b0;
         end
      join
      drain();

      // Reset in the middle of an operation owned by port 0
      send(0, 3'd6, 12'd5, 12'd6); req0 = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_alu", {5'd0, alu_op, alu_a, alu_b[11:0]} & 32'h07FF_FFFF, 32'd0);
      chk("midrst_rsp", {rsp_z0, rsp_z1, rsp_flags0, rsp_flags1, rsp_valid0, rsp_valid1}, 32'd0);
      q0.delete(); q1.delete();
      last_z0 = '0; last_z1 = '0; last_f0 = '0; last_f1 = '0;
      req0 = 1'b1; op0 = 3'd2; a0 = 12'h0F0; b0 = 12'h0FF;
      req1 = 1'b1; op1 = 3'd3; a1 = 12'h00F; b1 = 12'h0F0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("midrst_novalid", {30'd0, rsp_valid0, rsp_valid1}, 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("tie_after_reset", {30'd0, ready0, ready1}, 32'b10);
      @(posedge clk); #1;
      req0 = 1'b0;
      send(1, 3'd3, 12'h00F, 12'h0F0); req1 = 1'b0;
      drain();

      // SETTLE=3 instance: alu_* held and busy for 3 cycles, response 4 cycles after accept
      @(posedge clk); #1;
      t_req0 = 1'b1; t_op0 = 3'd3; t_a0 = 12'hF00; t_b0 = 12'h0F0;
      @(negedge clk);
      chk("s3_ready", 32'(t_ready0), 32'd1);
      @(posedge clk); #1;
      t_req0 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("s3_busy", 32'(t_busy), 32'd1);
         chk("s3_alu_hold", {5'd0, t_alu_op, t_alu_a, t_alu_b}, {5'd0, 3'd3, 12'hF00, 12'h0F0});
         chk("s3_novalid", 32'(t_valid0), 32'd0);
      end
      @(negedge clk);
      chk("s3_busy_end", 32'(t_busy), 32'd0);
      chk("s3_valid", 32'(t_valid0), 32'd1);
      chk("s3_z", 32'(t_z0), 32'hFF0);
      chk("s3_flags", 32'(t_flags0), 32'b010);
      chk("s3_valid1", 32'(t_valid1), 32'd0);
      @(negedge clk);
      chk("s3_valid_pulse", 32'(t_valid0), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "global timeout");
   end

endmodule
